// File: rtl/mac_datapath.sv
// -----------------------------------------------------------------------------
// mac_datapath
//
// Multiply-accumulate datapath that sits behind the control FSM. It issues an
// operand index upstream, multiplies the returned A/B pair into a product
// register (stage 0) and folds that product into an accumulator (stage 1).
// Every N_TERMS advancing cycles it publishes one dot product together with an
// overflow flag and a single-cycle DONE pulse. With RUN low the whole pipe
// holds its state, so a freeze simply delays the next result.
//
// Ports:
//   CLK         rising-edge clock
//   RESET       synchronous, active-high reset (wins over RUN)
//   RUN         advance enable from the FSM
//   A_IN, B_IN  operands for the index currently on IDX_OUT (unsigned)
//   IDX_OUT     operand index being issued
//   RESULT_OUT  last completed dot product (mod 2^ACC_WIDTH)
//   OVF_OUT     overflow flag belonging to RESULT_OUT
//   DONE        one-cycle pulse when RESULT_OUT/OVF_OUT are updated
// -----------------------------------------------------------------------------
module mac_datapath #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 18,
   parameter int N_TERMS   = 4,
   localparam int IDX_W    = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 RUN,
   input  logic [WIDTH-1:0]     A_IN,
   input  logic [WIDTH-1:0]     B_IN,
   output logic [IDX_W-1:0]     IDX_OUT,
   output logic [ACC_WIDTH-1:0] RESULT_OUT,
   output logic                 OVF_OUT,
   output logic                 DONE
);

   localparam int              PW       = 2 * WIDTH;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS - 1);

   // Stage 0: issued index and tagged product register
   logic [IDX_W-1:0]     r_idx;
   logic [PW-1:0]        r_p;
   logic                 r_p_valid;
   logic                 r_p_first;
   logic                 r_p_last;

   // Stage 1: running sum, sticky overflow and published result
   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_ovf;
   logic [ACC_WIDTH-1:0] r_result;
   logic                 r_ovf_out;
   logic                 r_done;

   logic [PW-1:0]        w_prod;
   logic [ACC_WIDTH-1:0] w_p_ext;
   logic                 w_p_hi_nz;
   logic [ACC_WIDTH:0]   w_sum;
   logic [ACC_WIDTH-1:0] w_acc_next;
   logic                 w_ovf_next;

   assign w_prod = {{WIDTH{1'b0}}, A_IN} * {{WIDTH{1'b0}}, B_IN};

   // Fit the product to the accumulator width. Product bits that do not fit
   // are lost, so any of them being set counts as overflow.
   generate
      if (PW > ACC_WIDTH) begin : g_p_trunc
         assign w_p_ext   = r_p[ACC_WIDTH-1:0];
         assign w_p_hi_nz = |r_p[PW-1:ACC_WIDTH];
      end else if (PW == ACC_WIDTH) begin : g_p_same
         assign w_p_ext   = r_p;
         assign w_p_hi_nz = 1'b0;
      end else begin : g_p_zext
         assign w_p_ext   = {{(ACC_WIDTH-PW){1'b0}}, r_p};
         assign w_p_hi_nz = 1'b0;
      end
   endgenerate

   // The extra top bit of the sum is the carry out of the accumulator.
   assign w_sum = {1'b0, r_acc} + {1'b0, w_p_ext};

   // NOTE: every signal driven here gets a value on every path (defaults
   // first), otherwise synthesis infers a latch to hold the missing case.
   always_comb begin
      w_acc_next = w_sum[ACC_WIDTH-1:0];
      w_ovf_next = r_ovf | w_sum[ACC_WIDTH] | w_p_hi_nz;
      if (r_p_first) begin
         // First term of a set loads instead of adding, which discards the
         // previous set's sum and overflow without needing a bubble cycle.
         w_acc_next = w_p_ext;
         w_ovf_next = w_p_hi_nz;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, which is what makes the two stages a pipe.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_idx     <= '0;
         r_p       <= '0;
         r_p_valid <= 1'b0;
         r_p_first <= 1'b0;
         r_p_last  <= 1'b0;
         r_acc     <= '0;
         r_ovf     <= 1'b0;
         r_result  <= '0;
         r_ovf_out <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (RUN) begin
            r_p       <= w_prod;
            r_p_valid <= 1'b1;
            r_p_first <= (r_idx == '0);
            r_p_last  <= (r_idx == LAST_IDX);
            r_idx     <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;

            if (r_p_valid) begin
               r_acc <= w_acc_next;
               r_ovf <= w_ovf_next;
               if (r_p_last) begin
                  r_result  <= w_acc_next;
                  r_ovf_out <= w_ovf_next;
                  r_done    <= 1'b1;
               end
            end
         end
      end
   end

   assign IDX_OUT    = r_idx;
   assign RESULT_OUT = r_result;
   assign OVF_OUT    = r_ovf_out;
   assign DONE       = r_done;

endmodule

// File: tb/tb_mac_datapath.sv
// -----------------------------------------------------------------------------
// tb_mac_datapath
//
// Drives two mac_datapath instances in lockstep: one at the default 18-bit
// accumulator and one with a 16-bit accumulator so overflow can be exercised.
// Operands come from a per-index table, acting as the upstream operand store.
// A transaction-level reference model sums each set of N_TERMS products with
// plain integer arithmetic and publishes the set one advancing edge later.
// -----------------------------------------------------------------------------
module tb_mac_datapath;

   localparam int WIDTH   = 8;
   localparam int N_TERMS = 4;
   localparam int ACC_A   = 18;
   localparam int ACC_B   = 16;
   localparam int IDX_W   = $clog2(N_TERMS);

   logic                 CLK = 1'b0;
   logic                 RESET = 1'b1;
   logic                 RUN = 1'b0;

   logic [WIDTH-1:0]     a_tab [N_TERMS];
   logic [WIDTH-1:0]     b_tab [N_TERMS];

   logic [WIDTH-1:0]     a_in_a, b_in_a, a_in_b, b_in_b;
   logic [IDX_W-1:0]     idx_a, idx_b;
   logic [ACC_A-1:0]     res_a;
   logic [ACC_B-1:0]     res_b;
   logic                 ovf_a, ovf_b, done_a, done_b;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int      m_idx;
   longint  m_set_sum;
   longint  m_pend_sum;
   bit      m_pend;
   longint  m_res_a, m_res_b;
   bit      m_ovf_a, m_ovf_b, m_done;

   always #5 CLK = ~CLK;

   assign a_in_a = a_tab[idx_a];
   assign b_in_a = b_tab[idx_a];
   assign a_in_b = a_tab[idx_b];
   assign b_in_b = b_tab[idx_b];

   mac_datapath #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_A), .N_TERMS(N_TERMS)) dut_a (
      .CLK(CLK), .RESET(RESET), .RUN(RUN), .A_IN(a_in_a), .B_IN(b_in_a),
      .IDX_OUT(idx_a), .RESULT_OUT(res_a), .OVF_OUT(ovf_a), .DONE(done_a)
   );

   mac_datapath #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_B), .N_TERMS(N_TERMS)) dut_b (
      .CLK(CLK), .RESET(RESET), .RUN(RUN), .A_IN(a_in_b), .B_IN(b_in_b),
      .IDX_OUT(idx_b), .RESULT_OUT(res_b), .OVF_OUT(ovf_b), .DONE(done_b)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock: apply controls, advance the model, then compare after the edge.
   task automatic step(input bit run, input bit rst);
      @(negedge CLK);
      RUN   = run;
      RESET = rst;
      if (rst) begin
         m_idx = 0; m_set_sum = 0; m_pend = 0; m_pend_sum = 0;
         m_res_a = 0; m_res_b = 0; m_ovf_a = 0; m_ovf_b = 0; m_done = 0;
      end else if (run) begin
         m_done = 0;
         if (m_pend) begin
            m_res_a = m_pend_sum % (64'd1 << ACC_A);
            m_res_b = m_pend_sum % (64'd1 << ACC_B);
            m_ovf_a = (m_pend_sum >= (64'd1 << ACC_A));
            m_ovf_b = (m_pend_sum >= (64'd1 << ACC_B));
            m_done  = 1;
            m_pend  = 0;
         end
         m_set_sum += longint'(a_tab[m_idx]) * longint'(b_tab[m_idx]);
         if (m_idx == N_TERMS - 1) begin
            m_pend     = 1;
            m_pend_sum = m_set_sum;
            m_set_sum  = 0;
         end
         m_idx = (m_idx + 1) % N_TERMS;
      end else begin
         m_done = 0;
      end
      @(posedge CLK);
      #1;
      check("idx_a",  idx_a,  m_idx);
      check("idx_b",  idx_b,  m_idx);
      check("done_a", done_a, m_done);
      check("done_b", done_b, m_done);
      check("res_a",  res_a,  m_res_a);
      check("res_b",  res_b,  m_res_b);
      check("ovf_a",  ovf_a,  m_ovf_a);
      check("ovf_b",  ovf_b,  m_ovf_b);
   endtask

   task automatic set_tab(input int a_mode, input int b_val);
      for (int i = 0; i < N_TERMS; i++) begin
         a_tab[i] = (a_mode < 0) ? WIDTH'(i + 1) : WIDTH'(a_mode);
         b_tab[i] = WIDTH'(b_val);
      end
   endtask

   initial begin
      int     n_done;
      longint held;

      set_tab(-1, 2);

      // Reset state
      step(0, 1);
      step(0, 1);
      check("rst_idx", idx_a, 0);
      check("rst_res", res_a, 0);
      check("rst_ovf", ovf_a, 0);
      check("rst_done", done_a, 0);

      // Basic: A=idx+1, B=2 gives 2*(1+2+3+4)=20 after the 5th RUN edge
      for (int k = 1; k <= 5; k++) begin
         step(1, 0);
         check("basic_done", done_a, (k == 5));
      end
      check("basic_res", res_a, 20);
      check("basic_ovf", ovf_a, 0);

      // Continuity: 16 edges, pulses at edges 5, 9 and 13
      step(0, 1);
      n_done = 0;
      for (int k = 1; k <= 16; k++) begin
         step(1, 0);
         check("cont_done", done_a, (k % 4 == 1) && (k > 1));
         if (done_a) begin
            n_done++;
            check("cont_res", res_a, 20);
         end
      end
      check("cont_pulses", n_done, 3);

      // Freeze two edges once IDX_OUT reaches 2, DONE arrives 2 edges late
      step(0, 1);
      step(1, 0);
      step(1, 0);
      check("frz_idx", idx_a, 2);
      held = res_a;
      for (int k = 0; k < 2; k++) begin
         step(0, 0);
         check("frz_idx_hold", idx_a, 2);
         check("frz_res_hold", res_a, held);
      end
      step(1, 0);
      step(1, 0);
      check("frz_early", done_a, 0);
      step(1, 0);
      check("frz_done", done_a, 1);
      check("frz_res", res_a, 20);
      step(1, 0);
      check("frz_pulse_width", done_a, 0);

      // Reset mid-operation with RUN still high
      step(0, 1);
      for (int k = 0; k < 6; k++) step(1, 0);
      check("mid_pre_idx", idx_a, 2);
      check("mid_pre_res", res_a, 20);
      step(1, 1);
      check("mid_idx", idx_a, 0);
      check("mid_res", res_a, 0);
      check("mid_done", done_a, 0);
      for (int k = 0; k < 5; k++) step(1, 0);
      check("mid_after_res", res_a, 20);
      check("mid_after_done", done_a, 1);

      // Overflow at 16 bits, no overflow at 18 bits, then sticky clear
      set_tab(255, 255);
      step(0, 1);
      for (int k = 0; k < 4; k++) step(1, 0);
      set_tab(1, 1);
      step(1, 0);
      check("ovf16_res", res_b, 63492);
      check("ovf16_flag", ovf_b, 1);
      check("max18_res", res_a, 260100);
      check("max18_flag", ovf_a, 0);
      for (int k = 0; k < 4; k++) step(1, 0);
      check("clr16_res", res_b, 4);
      check("clr16_flag", ovf_b, 0);
      check("clr16_done", done_b, 1);

      // Zero operands: result 0 with unchanged DONE timing
      set_tab(0, 255);
      step(0, 1);
      for (int k = 1; k <= 5; k++) begin
         step(1, 0);
         check("zero_done", done_a, (k == 5));
      end
      check("zero_res", res_a, 0);

      // Randomized traffic against the model
      step(0, 1);
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 9) == 0) begin
            for (int i = 0; i < N_TERMS; i++) begin
               a_tab[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : WIDTH'($urandom);
               b_tab[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : WIDTH'($urandom);
            end
         end
         step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
